// File: rtl/button_pkg.sv
// Shared constants, width helper and per-channel event payload for the button conditioner.
package button_pkg;

    localparam int unsigned CHANNELS_MIN      = 1;
    localparam int unsigned CHANNELS_MAX      = 32;
    localparam int unsigned DELAY_MIN         = 1;
    localparam int unsigned REPEAT_START_MIN  = 1;
    localparam int unsigned REPEAT_PERIOD_MIN = 1;

    typedef struct packed {
        logic clean;
        logic rise;
        logic fall;
        logic press;
    } btn_evt_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw switch inputs and conditioned per-channel outputs of the button conditioner.
interface button_conditioner_if #(
    parameter int unsigned CHANNELS = 4
) ();

    logic [CHANNELS-1:0] noisy;
    logic [CHANNELS-1:0] repeat_en;
    logic [CHANNELS-1:0] clean;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] press;

    modport master (
        output noisy,
        output repeat_en,
        input  clean,
        input  rise,
        input  fall,
        input  press
    );

    modport slave (
        input  noisy,
        input  repeat_en,
        output clean,
        output rise,
        output fall,
        output press
    );

endinterface

// File: rtl/debounce_channel.sv
// One channel: 2-flop synchroniser, stability-count debounce, edge pulses and auto-repeat.
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned DELAY         = 400000,
    parameter int unsigned REPEAT_START  = 24500000,
    parameter int unsigned REPEAT_PERIOD = 4900000
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     noisy_i,
    input  logic     repeat_en_i,
    output btn_evt_t evt_o
);

    localparam int unsigned CNT_W     = clog2(DELAY + 1);
    localparam int unsigned RMAX      = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
    localparam int unsigned RCNT_W    = (clog2(RMAX) > 0) ? clog2(RMAX) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DELAY);
    localparam logic [RCNT_W-1:0] RCNT_START = RCNT_W'(REPEAT_START - 1);
    localparam logic [RCNT_W-1:0] RCNT_PER   = RCNT_W'(REPEAT_PERIOD - 1);

    logic              s1_q, s2_q;
    logic              cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              clean_q, clean_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              press_q, press_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              first_q, first_d;
    logic              rep_ev;

    // Debounce: candidate must stay unchanged for DELAY counted cycles before clean follows.
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            clean_d = cand_q;
        end
    end

    // Auto-repeat timer; cleared on the rise edge because clean_q is still 0 there.
    always_comb begin
        rcnt_d  = rcnt_q;
        first_d = first_q;
        rep_ev  = 1'b0;
        if (!clean_q || !repeat_en_i) begin
            rcnt_d  = '0;
            first_d = 1'b1;
        end else if (first_q && (rcnt_q == RCNT_START)) begin
            rep_ev  = 1'b1;
            rcnt_d  = '0;
            first_d = 1'b0;
        end else if (!first_q && (rcnt_q == RCNT_PER)) begin
            rep_ev = 1'b1;
            rcnt_d = '0;
        end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
        end
    end

    // A repeat is dropped on the falling edge and never directly follows another press.
    always_comb begin
        rise_d  = clean_d & ~clean_q;
        fall_d  = ~clean_d & clean_q;
        press_d = rise_d | (rep_ev & clean_d & ~press_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cand_q  <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= 1'b0;
            rcnt_q  <= '0;
            first_q <= 1'b1;
        end else begin
            s1_q    <= noisy_i;
            s2_q    <= s1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= press_d;
            rcnt_q  <= rcnt_d;
            first_q <= first_d;
        end
    end

    assign evt_o.clean = clean_q;
    assign evt_o.rise  = rise_q;
    assign evt_o.fall  = fall_q;
    assign evt_o.press = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: one independent debounce_channel per input bit.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned DELAY         = 400000,
    parameter int unsigned REPEAT_START  = 24500000,
    parameter int unsigned REPEAT_PERIOD = 4900000
) (
    input logic                  clock,
    input logic                  reset,
    button_conditioner_if.slave  bus
);

    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("button_conditioner: CHANNELS out of range");
    end
    if (DELAY < DELAY_MIN) begin : g_bad_delay
        $error("button_conditioner: DELAY below minimum");
    end
    if (REPEAT_START < REPEAT_START_MIN) begin : g_bad_rstart
        $error("button_conditioner: REPEAT_START below minimum");
    end
    if (REPEAT_PERIOD < REPEAT_PERIOD_MIN) begin : g_bad_rperiod
        $error("button_conditioner: REPEAT_PERIOD below minimum");
    end

    btn_evt_t evt [CHANNELS];

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        debounce_channel #(
            .DELAY         (DELAY),
            .REPEAT_START  (REPEAT_START),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_channel (
            .clk_i       (clock),
            .rst_i       (reset),
            .noisy_i     (bus.noisy[ch]),
            .repeat_en_i (bus.repeat_en[ch]),
            .evt_o       (evt[ch])
        );

        assign bus.clean[ch] = evt[ch].clean;
        assign bus.rise[ch]  = evt[ch].rise;
        assign bus.fall[ch]  = evt[ch].fall;
        assign bus.press[ch] = evt[ch].press;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DELAY=4, REPEAT_START=10, REPEAT_PERIOD=3.
module tb_button_conditioner;

    localparam int unsigned CHANNELS      = 4;
    localparam int unsigned DELAY         = 4;
    localparam int unsigned REPEAT_START  = 10;
    localparam int unsigned REPEAT_PERIOD = 3;

    logic clock = 1'b0;
    logic reset;
    int   vectors    = 0;
    int   miscompares = 0;

    button_conditioner_if #(.CHANNELS(CHANNELS)) bus ();

    button_conditioner #(
        .CHANNELS      (CHANNELS),
        .DELAY         (DELAY),
        .REPEAT_START  (REPEAT_START),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bus.noisy     = '0;
        bus.repeat_en = '0;
        reset         = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        reset         = 1'b1;
        bus.noisy     = 4'hF;
        bus.repeat_en = 4'hF;
        for (int c = 0; c < 6; c++) begin
            step();
            obs = {bus.clean, bus.rise, bus.fall, bus.press};
            vectors++;
            if (obs !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_hold c=%0d got %h exp %h", c, obs, 16'h0000);
            end
        end
        bus.noisy     = '0;
        bus.repeat_en = '0;
        reset         = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            obs = {bus.clean, bus.rise, bus.fall, bus.press};
            vectors++;
            if (obs !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_idle c=%0d got %h exp %h", c, obs, 16'h0000);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [15:0] obs, expv;
        logic [3:0]  ec, er, ef, ep;
        bus.repeat_en = '0;
        for (int c = 0; c < 22; c++) begin
            bus.noisy = {3'b000, (c < 10)};
            step();
            ec = (c >= 7 && c <= 16) ? 4'b0001 : 4'b0000;
            er = (c == 7)  ? 4'b0001 : 4'b0000;
            ef = (c == 17) ? 4'b0001 : 4'b0000;
            ep = er;
            expv = {ec, er, ef, ep};
            obs  = {bus.clean, bus.rise, bus.fall, bus.press};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL clean_press c=%0d got %h exp %h", c, obs, expv);
            end
        end
    endtask

    task automatic test_bounce();
        logic [15:0] obs;
        for (int c = 0; c < 40; c++) begin
            bus.noisy = (c < 30 && ((c / 3) % 2) == 1) ? 4'b0010 : 4'b0000;
            step();
            obs = {bus.clean, bus.rise, bus.fall, bus.press};
            vectors++;
            if (obs !== 16'h0000) begin
                miscompares++;
                $display("FAIL bounce c=%0d got %h exp %h", c, obs, 16'h0000);
            end
        end
    endtask

    task automatic test_glitch_boundary();
        logic [15:0] obs, expv;
        logic [3:0]  ec, er, ef;
        // A 5-cycle pulse is the longest that must be rejected.
        for (int c = 0; c < 15; c++) begin
            bus.noisy = (c < 5) ? 4'b0010 : 4'b0000;
            step();
            obs = {bus.clean, bus.rise, bus.fall, bus.press};
            vectors++;
            if (obs !== 16'h0000) begin
                miscompares++;
                $display("FAIL glitch5 c=%0d got %h exp %h", c, obs, 16'h0000);
            end
        end
        for (int c = 0; c < 18; c++) begin
            bus.noisy = (c < 6) ? 4'b0010 : 4'b0000;
            step();
            ec = (c >= 7 && c <= 12) ? 4'b0010 : 4'b0000;
            er = (c == 7)  ? 4'b0010 : 4'b0000;
            ef = (c == 13) ? 4'b0010 : 4'b0000;
            expv = {ec, er, ef, er};
            obs  = {bus.clean, bus.rise, bus.fall, bus.press};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL glitch6 c=%0d got %h exp %h", c, obs, expv);
            end
        end
    endtask

    task automatic test_auto_repeat();
        logic [15:0] obs, expv;
        logic [3:0]  ec, er, ef, ep;
        bus.repeat_en = 4'b0100;
        for (int c = 0; c < 46; c++) begin
            bus.noisy = (c < 31) ? 4'b0100 : 4'b0000;
            step();
            ec = (c >= 7 && c <= 37) ? 4'b0100 : 4'b0000;
            er = (c == 7)  ? 4'b0100 : 4'b0000;
            ef = (c == 38) ? 4'b0100 : 4'b0000;
            ep = ((c == 7) || (c >= 17 && c <= 37 && ((c - 17) % 3) == 0)) ? 4'b0100 : 4'b0000;
            expv = {ec, er, ef, ep};
            obs  = {bus.clean, bus.rise, bus.fall, bus.press};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL auto_repeat c=%0d got %h exp %h", c, obs, expv);
            end
        end
        bus.repeat_en = '0;
    endtask

    task automatic test_repeat_toggle();
        logic [15:0] obs, expv;
        logic [3:0]  ec, er, ef, ep;
        for (int c = 0; c < 50; c++) begin
            bus.noisy     = (c < 38) ? 4'b0100 : 4'b0000;
            bus.repeat_en = (c >= 21 && c <= 24) ? 4'b0000 : 4'b0100;
            step();
            ec = (c >= 7 && c <= 44) ? 4'b0100 : 4'b0000;
            er = (c == 7)  ? 4'b0100 : 4'b0000;
            ef = (c == 45) ? 4'b0100 : 4'b0000;
            ep = (c == 7 || c == 17 || c == 20 || c == 34 || c == 37 || c == 40 || c == 43)
                 ? 4'b0100 : 4'b0000;
            expv = {ec, er, ef, ep};
            obs  = {bus.clean, bus.rise, bus.fall, bus.press};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL repeat_toggle c=%0d got %h exp %h", c, obs, expv);
            end
        end
        bus.repeat_en = '0;
    endtask

    task automatic test_repeat_disable();
        logic [15:0] obs, expv;
        logic [3:0]  ec, er, ef;
        bus.repeat_en = '0;
        for (int c = 0; c < 62; c++) begin
            bus.noisy = (c < 50) ? 4'b1000 : 4'b0000;
            step();
            ec = (c >= 7 && c <= 56) ? 4'b1000 : 4'b0000;
            er = (c == 7)  ? 4'b1000 : 4'b0000;
            ef = (c == 57) ? 4'b1000 : 4'b0000;
            expv = {ec, er, ef, er};
            obs  = {bus.clean, bus.rise, bus.fall, bus.press};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL repeat_disable c=%0d got %h exp %h", c, obs, expv);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] obs, expv;
        logic [3:0]  ec, er, ef;
        // Bring channel 3 high first so reset visibly clears an active output.
        bus.repeat_en = '0;
        bus.noisy     = 4'b1000;
        for (int i = 0; i < 10; i++) step();
        for (int c = 0; c < 30; c++) begin
            bus.noisy = (c < 20) ? 4'b1001 : 4'b0000;
            reset     = (c == 5);
            step();
            ec = (c >= 13 && c <= 26) ? 4'b1001 : ((c < 5) ? 4'b1000 : 4'b0000);
            er = (c == 13) ? 4'b1001 : 4'b0000;
            ef = (c == 27) ? 4'b1001 : 4'b0000;
            expv = {ec, er, ef, er};
            obs  = {bus.clean, bus.rise, bus.fall, bus.press};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL reset_mid c=%0d got %h exp %h", c, obs, expv);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [15:0] obs, expv;
        logic [3:0]  ec, er, ef;
        bus.repeat_en = '0;
        for (int c = 0; c < 24; c++) begin
            bus.noisy = (c < 12) ? 4'b1111 : 4'b0000;
            step();
            ec = (c >= 7 && c <= 18) ? 4'b1111 : 4'b0000;
            er = (c == 7)  ? 4'b1111 : 4'b0000;
            ef = (c == 19) ? 4'b1111 : 4'b0000;
            expv = {ec, er, ef, er};
            obs  = {bus.clean, bus.rise, bus.fall, bus.press};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL simultaneous c=%0d got %h exp %h", c, obs, expv);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.noisy     = '0;
        bus.repeat_en = '0;
        test_reset();
        test_clean_press();
        idle(5);
        test_bounce();
        idle(5);
        test_glitch_boundary();
        idle(5);
        test_auto_repeat();
        idle(5);
        test_repeat_toggle();
        idle(5);
        test_repeat_disable();
        idle(5);
        test_reset_mid();
        idle(5);
        test_simultaneous();
        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, legal range 1..32.
REQ-002 Parameter DELAY, default 400000: number of stable cycles required before the output follows the input, legal minimum 1.
REQ-003 Parameter REPEAT_START, default 24500000: number of cycles clean must stay high before the first auto-repeat pulse, legal minimum 1.
REQ-004 Parameter REPEAT_PERIOD, default 4900000: number of cycles between later auto-repeat pulses, legal minimum 1.
REQ-005 clock  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 noisy  input  CHANNELS  raw asynchronous switch inputs, one bit per channel.
REQ-008 repeat_en  input  CHANNELS  per-channel auto-repeat enable, synchronous to clock.
REQ-009 clean  output  CHANNELS  debounced level per channel, registered.
REQ-010 rise  output  CHANNELS  one-cycle pulse on each 0->1 transition of clean, registered.
REQ-011 fall  output  CHANNELS  one-cycle pulse on each 1->0 transition of clean, registered.
REQ-012 press  output  CHANNELS  one-cycle pulse on rise OR on an auto-repeat event, registered.

Function
REQ-013 Each channel passes through a 2-flop synchroniser (s1, then s2) before any other logic uses it.
REQ-014 Each channel holds a candidate bit cand and a counter cnt of width clog2(DELAY+1).
  - If s2 != cand: cand <= s2 and cnt <= 0.
  - Else if cnt < DELAY: cnt <= cnt+1.
  - Else (cnt == DELAY): clean <= cand.
REQ-015 Latency: a level that is first sampled into s1 at edge k and then held appears on clean at edge k+DELAY+3.
REQ-016 Any glitch that reaches s2 and lasts DELAY+1 cycles or fewer never changes clean.
REQ-017 rise is asserted at the same edge that clean goes 0->1, and fall at the same edge that clean goes 1->0; each stays high for exactly one cycle.
REQ-018 Auto-repeat uses a per-channel counter rcnt, sized for max(REPEAT_START, REPEAT_PERIOD), and a flag first.
  - rcnt is cleared, and first is set, while clean=0, while repeat_en=0, and on the rise cycle.
  - While clean=1 and repeat_en=1, rcnt increments each cycle.
  - When rcnt reaches REPEAT_START-1 while first=1, a repeat event is generated, rcnt <= 0 and first <= 0.
  - When rcnt reaches REPEAT_PERIOD-1 while first=0, a repeat event is generated and rcnt <= 0.
REQ-019 press = rise OR repeat event, registered so that both have the same timing; press is never high for two consecutive cycles.
REQ-020 Deasserting repeat_en mid-hold suppresses repeat events from the next cycle onward and restarts the REPEAT_START interval if repeat_en is re-enabled.
REQ-021 When clean falls, auto-repeat stops immediately; a repeat event cannot coincide with fall.
REQ-022 Channels are fully independent; simultaneous events on multiple channels are all reported in the same cycle.
REQ-023 Counters never wrap: cnt saturates at DELAY, and rcnt is always reset before it overflows.

Reset
REQ-024 While reset=1, at each edge: s1, s2, cand, cnt, rcnt, clean, rise, fall and press all go to 0, and first goes to 1.
REQ-025 Reset asserted mid-count discards the partial count; after reset releases, any input held high produces a normal rise at edge DELAY+3 after release.
REQ-026 Reset has priority over all other logic in every channel.

Structure
REQ-027 A shared package button_pkg holds the constant function for counter width (clog2) and the parameter legality limits; the limits are checked at elaboration.
REQ-028 The per-channel logic (synchroniser, debounce, edges, repeat) lives in one sub-module, debounce_channel, instantiated CHANNELS times in a generate loop.
REQ-029 The top level contains no logic beyond instantiation and bit-slicing.

Verification (CHANNELS=4, DELAY=4, REPEAT_START=10, REPEAT_PERIOD=3)
REQ-030 Clean press: noisy[0] goes 0->1 and is held, first sampled at edge k -> clean[0]=1 at edge k+7, with rise[0]=1 and press[0]=1 for one cycle.
REQ-031 Bounce rejection: noisy[1] toggles every 3 cycles for 30 cycles, then is held at 0 -> clean[1] stays 0, and rise[1], fall[1] and press[1] never assert.
REQ-032 Auto-repeat: with repeat_en[2]=1, noisy[2] is held high -> press[2] pulses at the rise edge, 10 cycles later, then every 3 cycles; on release, fall[2] pulses once and press[2] stops.
REQ-033 Repeat disable: with repeat_en[3]=0, noisy[3] is held high for 50 cycles -> exactly one press[3] pulse.
REQ-034 Reset mid-count: noisy[0] is held high and reset is pulsed 2 cycles before clean would rise -> all outputs are 0 during reset, and clean[0] rises 7 edges after reset releases.
REQ-035 Simultaneous events: all four inputs rise on the same edge -> rise=4'b1111 on a single cycle.
